// File: rtl/or8way_selftest.sv
// ----------------------------------------------------------------------------
// or8way_selftest
//
// On-chip stimulus generator and response checker for an 8-way OR reduction
// gate. A run drives patterns 0..PAT_NUM-1 onto pat_out. Each pattern is held
// for SETTLE_CYCLES cycles plus one check cycle. In the check cycle the gate
// response dut_in is compared against the OR-reduction of pat_out.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          begins a run (sampled only in IDLE or DONE)
//   pat_out[7:0]   pattern driven to the gate input
//   dut_in         gate output under test
//   busy           run in progress (SETTLE or CHECK)
//   done           run finished; held until the next start or rst
//   pass           valid with done: every checked pattern matched
//   fail_count     mismatches in the current/last run (saturates at 511)
//   first_fail_idx index of the first mismatching pattern
//   first_fail_vld first_fail_idx holds a captured value
// ----------------------------------------------------------------------------
module or8way_selftest #(
  parameter int PAT_NUM       = 256,
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] pat_out,
  input  logic       dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] fail_count,
  output logic [7:0] first_fail_idx,
  output logic       first_fail_vld
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX    = 8'(PAT_NUM - 1);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [8:0] FAIL_MAX    = 9'd511;

  state_t     state;
  logic [7:0] idx;
  logic [3:0] settle_cnt;
  logic       golden;
  logic       mismatch;

  // Golden response is derived from the pattern actually on the gate input,
  // which is stable for the whole SETTLE/CHECK window of a pattern.
  assign golden   = |pat_out;
  assign mismatch = (dut_in != golden);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 8'd0;
      settle_cnt     <= 4'd0;
      pat_out        <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= 9'd0;
      first_fail_idx <= 8'd0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A start from DONE behaves exactly like a start from IDLE.
          if (start) begin
            idx            <= 8'd0;
            pat_out        <= 8'd0;
            settle_cnt     <= SETTLE_INIT;
            fail_count     <= 9'd0;
            first_fail_idx <= 8'd0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            state          <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            state <= CHECK;
          end
        end

        CHECK: begin
          if (mismatch) begin
            if (fail_count != FAIL_MAX) begin
              fail_count <= fail_count + 9'd1;
            end
            if (!first_fail_vld) begin
              first_fail_idx <= idx;
              first_fail_vld <= 1'b1;
            end
          end

          if (mismatch && STOP_ON_FAIL) begin
            pass  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (idx == LAST_IDX) begin
            // fail_count is still the pre-update value here, so the mismatch
            // of this very cycle has to be folded in separately.
            pass  <= (fail_count == 9'd0) && !mismatch;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx        <= idx + 8'd1;
            pat_out    <= idx + 8'd1;
            settle_cnt <= SETTLE_INIT;
            state      <= SETTLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/or8way_selftest.md
Name: or8way_selftest

Overview:
Sequential on-chip stimulus generator and response checker for the 8-way OR reduction gate. It plays the same role as the gate's simulation testbench, but in synthesizable RTL. It drives 8-bit patterns 0..PAT_NUM-1 onto the gate input, samples the gate output and compares it against an internally computed golden value (OR-reduction of the pattern). It reports pass/fail, a mismatch count and the first failing pattern index. It sits beside the gate instance in the self-test wrapper and is started by a single pulse.

Parameters:
PAT_NUM, 256, number of patterns driven; legal range 1..256.
SETTLE_CYCLES, 1, cycles each pattern is held before the response is sampled; legal range 1..15.
STOP_ON_FAIL, 0, 1 = end the run at the first mismatch; 0 = run all patterns.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begins a run; sampled only in IDLE or DONE
pat_out  output  8  pattern driven to the gate input
dut_in  input  1  gate output under test
busy  output  1  high while a run is in progress (SETTLE or CHECK)
done  output  1  high in DONE; held until next start or rst
pass  output  1  valid when done=1; 1 = every checked pattern matched and the run completed
fail_count  output  9  number of mismatches in the current or last run
first_fail_idx  output  8  index of the first mismatching pattern
first_fail_vld  output  1  first_fail_idx holds a captured value

Behaviour:
- Reset (async, rst=1): state=IDLE. pat_out=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0, first_fail_vld=0, idx=0, settle_cnt=0. The effect is immediate, including mid-run. After rst deasserts, the block stays in IDLE until start.
- Internal state: idx (8-bit pattern index), settle_cnt (4-bit), golden = OR-reduction of pat_out.
- IDLE:
  - start=1 -> idx<=0, pat_out<=0x00, settle_cnt<=SETTLE_CYCLES-1, fail_count<=0, first_fail_vld<=0, first_fail_idx<=0, pass<=0 -> SETTLE.
- SETTLE (busy=1):
  - settle_cnt!=0 -> settle_cnt decrements by 1.
  - settle_cnt==0 -> CHECK.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK (busy=1, one cycle): compare dut_in with golden.
  - Mismatch:
    - fail_count<=fail_count+1, saturating at 511.
    - If first_fail_vld=0: first_fail_idx<=idx, first_fail_vld<=1.
  - Next state, in priority order:
    1. Mismatch and STOP_ON_FAIL=1 -> DONE, pass<=0.
    2. idx==PAT_NUM-1 -> DONE, pass<=(no mismatch this run, including this cycle).
    3. Otherwise idx<=idx+1, pat_out<=idx+1, settle_cnt<=SETTLE_CYCLES-1 -> SETTLE.
- DONE (done=1, busy=0):
  - pat_out holds the last driven pattern. All result outputs hold.
  - start=1 -> identical to start in IDLE (clears results, restarts from pattern 0) -> SETTLE.
- start is ignored while busy=1. Holding start high re-triggers only from IDLE or DONE.
- Timing: each pattern occupies SETTLE_CYCLES+1 cycles. For a full run without early stop, done rises at the clock edge PAT_NUM*(SETTLE_CYCLES+1) edges after the edge that sampled start.
- pat_out changes only on the edge entering SETTLE, so it is stable throughout SETTLE and CHECK.
- dut_in is sampled only in CHECK. Values on dut_in in other states have no effect.
- pass=0 whenever done=0.

Test Plan:
1. Ideal gate (dut_in = OR-reduction of pat_out), defaults, 1-cycle start pulse:
   - pat_out steps through 0x00..0xFF, each value held 2 cycles.
   - done rises 512 edges after start.
   - pass=1, fail_count=0, first_fail_vld=0.
2. Gate stuck-at-1, STOP_ON_FAIL=0:
   - Full 256-pattern run.
   - done=1, pass=0, fail_count=1, first_fail_idx=0x00, first_fail_vld=1.
3. Gate stuck-at-0, STOP_ON_FAIL=1:
   - Run ends after the CHECK of idx=1.
   - done=1, pass=0, fail_count=1, first_fail_idx=0x01, pat_out held at 0x01.
4. Ideal gate, rst pulsed while pat_out=0x64 during SETTLE:
   - All outputs zero in the same cycle, state IDLE.
   - Next start runs from 0x00 and ends with pass=1.
5. start held high for the entire run, then start pulse again in DONE:
   - No restart while busy.
   - Restart from DONE clears fail_count, first_fail_vld and pass, and re-runs from 0x00.
6. SETTLE_CYCLES=3, gate followed by a 2-flop delay:
   - Every pattern held 4 cycles.
   - pass=1, done at 1024 edges.
   - With SETTLE_CYCLES=1, the same delayed gate gives pass=0 with fail_count>0.
